ff_mac_stream_processor: RTL
============================

Name: ff_mac_stream_processor

Overview:
- Streaming feedforward processor set. Takes z activation/weight pairs per beat and accumulates fi/z beats per neuron.
- On the last beat it adds the bias and emits one saturated pre-activation or ReLU value.
- Successor to the single-cycle FF processor set: supports fan-in larger than z, valid/ready flow control, saturation, a flush, and a sticky saturation flag.
- Sits between weight/activation memories and the activation table / BP staging.

Parameters:
width, 16, total fixed-point bits, signed, equal to 1+int_bits+frac_bits
int_bits, 5, integer bits excluding sign
frac_bits, 10, fractional bits
z, 8, lanes (products) per beat, power of 2
fi, 16, fan-in per neuron; must be a multiple of z, so B = fi/z beats per neuron

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of the current neuron
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
a_package  in  width*z  activations, lane k at bits [width*(k+1)-1 : width*k]
w_package  in  width*z  weights, same packing
b  in  width  bias; sampled only on the last beat
act_mode  in  1  0 = linear, 1 = ReLU; sampled only on the last beat
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
result  out  width  neuron output
sat_flag  out  1  sticky; set on any saturation; cleared by reset or flush

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (reset_n). Reset drives in_ready=1, out_valid=0, result=0, sat_flag=0, beat counter=0, accumulator=0, and all stage valids to 0.
- Global advance enable: en = !out_valid || out_ready. in_ready = en. When en=0, every register holds.
- Beat counter runs 0..B-1. It increments on each accepted beat and wraps to 0 after B-1. A beat with counter == B-1 is "last". When B=1, every beat is last.
- Stage M (registered on accept):
  - Per lane: product = a*w as a signed 2*width-bit value, arithmetic-shifted right by frac_bits (truncation toward -inf), then saturated to width bits.
  - Also registers the last flag, plus b and act_mode when the beat is last.
- Stage A:
  - Adds the z registered products in a tree at full precision (ACC = width+clog2(fi)+1 bits) into the accumulator.
  - On a last beat, the value acc+sum+bias is saturated to width bits, with ReLU applied after saturation when act_mode=1. It is written to result with out_valid=1, and the accumulator clears to 0.
  - On a non-last beat, the accumulator takes acc+sum.
- Latency: the result is valid exactly 2 cycles after the last beat is accepted, absent backpressure. Throughput is one beat per cycle.
- Saturation limits: max = 2^(width-1)-1, min = -2^(width-1). Any lane-product clamp or final clamp sets sat_flag on the cycle after it occurs. Values clipped to 0 by ReLU do not set the flag.
- Output hold: while out_valid && !out_ready, result and all pipeline contents stay stable and in_ready=0.
- A handshake completing with no new result clears out_valid. A simultaneous completion and new result presents the new value in the same cycle (no bubble).
- flush (priority over in_valid):
  - Next edge: beat counter=0, accumulator=0, stage M valid=0, sat_flag=0.
  - A result already in the output register is kept; flush does not drop out_valid.
  - The beat presented during the flush cycle is not accepted (in_ready=0 that cycle).
- Reset mid-neuron discards all partial state. The first beat accepted after release is beat 0.

Test Plan:
1. z=4, fi=8 (B=2); all a=0x0400 (1.0), w=0x0200 (0.5), b=0x0100, act_mode=0 -> result=0x1100 (4.25), out_valid exactly 2 cycles after beat 2, sat_flag=0.
2. One lane a=0x3C00, w=0x3C00 (225), other lanes 0, b=0 -> result=0x7FFF, sat_flag=1. Then a=0x8000, w=0x3C00 -> result=0x8000.
3. act_mode=1, all a=0x0400, w=0xFE00 (-0.5), b=0 -> result=0x0000. Same stimulus with act_mode=0 -> 0xF000 (-4.0).
4. Backpressure: hold out_ready=0 after a result -> in_ready=0, result stable for 5 cycles, no beat consumed. Raise out_ready -> next neuron result follows with correct value.
5. Accept beat 0, assert flush, then send 2 fresh beats as in test 1 -> result=0x1100, with no contribution from the flushed beat.
6. Pulse reset_n low mid-neuron after beat 0 -> all outputs at reset values. Two subsequent beats produce 0x1100.

Source files
------------

// File: rtl/ff_mac_stream_processor.sv
// Streaming MAC neuron: z saturated products per beat, fi/z beats per neuron,
// bias + final clamp + optional ReLU, valid/ready on both sides, flush and sticky saturation.
module ff_mac_stream_processor #(
    parameter int width     = 16,
    parameter int int_bits  = 5,
    parameter int frac_bits = 10,
    parameter int z         = 8,
    parameter int fi        = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [width*z-1:0] a_package,
    input  logic [width*z-1:0] w_package,
    input  logic [width-1:0]   b,
    input  logic               act_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [width-1:0]   result,
    output logic               sat_flag
);
    localparam int B     = fi / z;
    localparam int CW    = (B > 1) ? $clog2(B) : 1;
    localparam int ACC   = width + $clog2(fi) + 1;
    localparam int PW    = 2 * width;
    // The integer-bit count wins if the three format parameters disagree.
    localparam int SHIFT = (1 + int_bits + frac_bits == width) ? frac_bits : width - 1 - int_bits;

    localparam logic [width-1:0]      W_MAX   = {1'b0, {(width-1){1'b1}}};
    localparam logic [width-1:0]      W_MIN   = {1'b1, {(width-1){1'b0}}};
    localparam logic signed [PW-1:0]  P_MAX   = {{(PW-width+1){1'b0}}, {(width-1){1'b1}}};
    localparam logic signed [PW-1:0]  P_MIN   = {{(PW-width+1){1'b1}}, {(width-1){1'b0}}};
    localparam logic signed [ACC-1:0] ACC_MAX = {{(ACC-width+1){1'b0}}, {(width-1){1'b1}}};
    localparam logic signed [ACC-1:0] ACC_MIN = {{(ACC-width+1){1'b1}}, {(width-1){1'b0}}};

    // Returns {clamped, value} for a rescaled lane product.
    function automatic logic [width:0] sat_prod(input logic signed [PW-1:0] v);
        logic [width:0] r;
        if (v > P_MAX) r = {1'b1, W_MAX};
        else if (v < P_MIN) r = {1'b1, W_MIN};
        else r = {1'b0, v[width-1:0]};
        return r;
    endfunction

    // Returns {clamped, value} for the full-precision neuron total.
    function automatic logic [width:0] sat_acc(input logic signed [ACC-1:0] v);
        logic [width:0] r;
        if (v > ACC_MAX) r = {1'b1, W_MAX};
        else if (v < ACC_MIN) r = {1'b1, W_MIN};
        else r = {1'b0, v[width-1:0]};
        return r;
    endfunction

    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    m_valid_q, m_valid_d, m_last_q, m_last_d, m_mode_q, m_mode_d;
    logic signed [width-1:0] m_b_q, m_b_d;
    logic signed [width-1:0] prod_q [z];
    logic signed [width-1:0] prod_d [z];
    logic signed [ACC-1:0]   acc_q, acc_d;
    logic                    out_valid_q, out_valid_d, sat_q, sat_d;
    logic [width-1:0]        result_q, result_d;

    logic                    en_s, accept_s, last_in_s;
    logic signed [width-1:0] lane_val_s [z];
    logic [z-1:0]            lane_sat_s;
    logic signed [ACC-1:0]   sum_s, total_s;
    logic [width:0]          fin_sat_s;
    logic [width-1:0]        fin_val_s;

    assign en_s      = !out_valid_q || out_ready;
    assign accept_s  = in_valid && en_s && !flush;
    assign last_in_s = (cnt_q == CW'(B - 1));

    // Per-lane multiply, rescale (floor) and clamp of the presented beat.
    always_comb begin
        logic signed [PW-1:0] a_ext_v, w_ext_v, prod_v;
        logic [width:0]       sat_v;
        for (int k = 0; k < z; k++) begin
            a_ext_v       = PW'($signed(a_package[width*k +: width]));
            w_ext_v       = PW'($signed(w_package[width*k +: width]));
            prod_v        = (a_ext_v * w_ext_v) >>> SHIFT;
            sat_v         = sat_prod(prod_v);
            lane_val_s[k] = sat_v[width-1:0];
            lane_sat_s[k] = sat_v[width];
        end
    end

    // Pairwise adder tree over the registered products, then bias, clamp and ReLU.
    always_comb begin
        logic signed [ACC-1:0] node_v [2*z];
        node_v[0] = {ACC{1'b0}};
        for (int k = 0; k < z; k++) node_v[z+k] = ACC'(prod_q[k]);
        for (int n = z - 1; n >= 1; n--) node_v[n] = node_v[2*n] + node_v[2*n+1];
        sum_s     = node_v[1];
        total_s   = acc_q + sum_s + ACC'(m_b_q);
        fin_sat_s = sat_acc(total_s);
        if (m_mode_q && fin_sat_s[width-1]) fin_val_s = {width{1'b0}};
        else fin_val_s = fin_sat_s[width-1:0];
    end

    // Next-state logic for counter, stage M, stage A and the output register.
    always_comb begin
        cnt_d       = cnt_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_b_d       = m_b_q;
        m_mode_d    = m_mode_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        sat_d       = sat_q;
        if (flush) begin
            // A finished result survives the abort; only a completed handshake retires it.
            cnt_d       = {CW{1'b0}};
            acc_d       = {ACC{1'b0}};
            m_valid_d   = 1'b0;
            sat_d       = 1'b0;
            out_valid_d = out_valid_q && !out_ready;
        end else if (en_s) begin
            m_valid_d = accept_s;
            if (accept_s) begin
                prod_d   = lane_val_s;
                m_last_d = last_in_s;
                cnt_d    = last_in_s ? {CW{1'b0}} : cnt_q + 1'b1;
                if (last_in_s) begin
                    m_b_d    = b;
                    m_mode_d = act_mode;
                end else begin
                    m_b_d    = m_b_q;
                    m_mode_d = m_mode_q;
                end
            end else begin
                m_last_d = m_last_q;
                cnt_d    = cnt_q;
            end
            if (m_valid_q && m_last_q) begin
                out_valid_d = 1'b1;
                result_d    = fin_val_s;
                acc_d       = {ACC{1'b0}};
            end else if (m_valid_q) begin
                out_valid_d = 1'b0;
                acc_d       = acc_q + sum_s;
            end else begin
                out_valid_d = 1'b0;
                acc_d       = acc_q;
            end
            sat_d = sat_q | (accept_s & (|lane_sat_s)) | (m_valid_q & m_last_q & fin_sat_s[width]);
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= {CW{1'b0}};
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_b_q       <= {width{1'b0}};
            m_mode_q    <= 1'b0;
            for (int k = 0; k < z; k++) prod_q[k] <= {width{1'b0}};
            acc_q       <= {ACC{1'b0}};
            out_valid_q <= 1'b0;
            result_q    <= {width{1'b0}};
            sat_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_b_q       <= m_b_d;
            m_mode_q    <= m_mode_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = en_s && !flush;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign sat_flag  = sat_q;
endmodule
